multicycle_control_unit: RTL
============================

Name: multicycle_control_unit

Overview:
- Sequential successor to the single-cycle ALU/flag decode: a multicycle ARM-subset controller combining the main FSM, a widened ALU decoder, a condition-check unit and the NZCV flag register.
- Sits between the instruction register/ALU flags and the multicycle datapath.
- Drives every datapath enable and select, one FSM state per cycle.
- Adds EOR, TST and CMN over the previous decoder, plus S-bit-controlled flag writes, predicated execution and undefined-instruction reporting.

Parameters:
ALU_CTRL_W, 3, ALUControl width; 2 disables EOR, which then decodes as undefined.
PC_REG, 15, register index whose write also loads PC.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
Op  input  2  Instr[27:26]
Funct  input  6  Instr[25:20]: {I, cmd[3:0], S/L}
Rd  input  4  Instr[15:12]
Cond  input  4  Instr[31:28]
ALUFlags  input  4  {N,Z,C,V} from ALU, current cycle
PCWrite  output  1  PC load enable
MemWrite  output  1  data memory write
RegWrite  output  1  register file write
IRWrite  output  1  instruction register load
AdrSrc  output  1  0 = PC, 1 = ALU result register
RegSrc  output  2  [0]: Op==10; [1]: Op==01
ALUSrcA  output  2  00 = Rn, 01 = PC, 10 = ALU result register
ALUSrcB  output  2  00 = Rm, 01 = extended immediate, 10 = constant 4
ResultSrc  output  2  00 = ALU result register, 01 = data register, 10 = ALU direct
ImmSrc  output  2  equals Op (combinational)
ALUControl  output  ALU_CTRL_W  10 = ADD, 11 = SUB, 00 = AND, 01 = ORR, 100 = EOR (zero-extended codes)
Flags  output  4  registered NZCV
Undef  output  1  one-cycle pulse on undefined instruction

Behaviour:
- Reset, asynchronous while high:
  - state = FETCH; Flags = 0000; CondExReg = 0.
  - PCWrite, MemWrite, RegWrite, IRWrite, Undef all forced to 0.
  - Other outputs hold the FETCH values.
- Condition check, combinational on Cond and Flags:
  - Standard ARM EQ..LE.
  - 1110 (AL) = true; 1111 (NV) = false.
  - Result latched into CondExReg at the end of DECODE.
- ALU decode, active in EXECUTER/EXECUTEI:
  - cmd 0100 ADD: ctrl 10, write enabled.
  - cmd 0010 SUB: ctrl 11, write enabled.
  - cmd 0000 AND: ctrl 00, write enabled.
  - cmd 1100 ORR: ctrl 01, write enabled.
  - cmd 0001 EOR: ctrl 100, write enabled.
  - cmd 1010 CMP: ctrl 11, NoWrite.
  - cmd 1011 CMN: ctrl 10, NoWrite.
  - cmd 1000 TST: ctrl 00, NoWrite.
  - Any other cmd is undefined.
- FlagW:
  - ADD/SUB with S=1: 11 (NZ and CV).
  - AND/ORR/EOR with S=1: 10 (NZ only).
  - CMP/CMN: 11 regardless of S.
  - TST: 10 regardless of S.
  - Otherwise 00.
- Flag update at the end of EXECUTER/EXECUTEI when CondExReg = 1:
  - FlagW[1] = 1: N,Z ← ALUFlags[3:2].
  - FlagW[0] = 1: C,V ← ALUFlags[1:0].
- States and per-state outputs; unlisted enables are 0, unlisted selects are don't-care.
  - FETCH:
    - AdrSrc 0, IRWrite 1, ALUSrcA 01, ALUSrcB 10, ALUControl ADD, ResultSrc 10, PCWrite 1.
    - Next: DECODE.
  - DECODE:
    - ALUSrcA 01, ALUSrcB 10, ALUControl ADD, ResultSrc 10.
    - Op 01 → MEMADR.
    - Op 00 with Funct[5]=0 → EXECUTER.
    - Op 00 with Funct[5]=1 → EXECUTEI.
    - Op 10 → BRANCH.
    - Op 11, or undefined cmd, or EOR with ALU_CTRL_W=2 → FETCH with Undef = 1 for this cycle; no writes follow.
  - MEMADR:
    - ALUSrcA 00, ALUSrcB 01, ALUControl ADD.
    - Funct[0]=1 → MEMREAD; 0 → MEMWRITE.
  - MEMREAD: AdrSrc 1 → MEMWB.
  - MEMWB:
    - ResultSrc 01, RegWrite = CondExReg.
    - PCWrite = CondExReg & (Rd==PC_REG).
    - Next: FETCH.
  - MEMWRITE: AdrSrc 1, MemWrite = CondExReg → FETCH.
  - EXECUTER: ALUSrcA 00, ALUSrcB 00, decoded ALUControl → ALUWB.
  - EXECUTEI: ALUSrcA 00, ALUSrcB 01, decoded ALUControl → ALUWB.
  - ALUWB:
    - ResultSrc 00, RegWrite = CondExReg & ~NoWrite.
    - PCWrite = CondExReg & ~NoWrite & (Rd==PC_REG).
    - Next: FETCH.
  - BRANCH:
    - ALUSrcA 10, ALUSrcB 01, ALUControl ADD, ResultSrc 10, PCWrite = CondExReg.
    - Next: FETCH.
- Latency in cycles:
  - Data-processing: 4.
  - LDR: 5.
  - STR: 4.
  - Branch: 3.
  - Undefined: 2.
- Boundary cases:
  - A failed condition still walks the full state path with all writes suppressed and flags unchanged.
  - A flag write and the condition check on the next instruction see the updated Flags, because the check happens in the later DECODE.
  - Reset asserted mid-instruction aborts it; no write enable is high during or in the cycle after reset release except FETCH's own PCWrite/IRWrite.
  - Unreachable state encodings go to FETCH.

Test Plan:
- Reset high for 2 cycles, then release → state FETCH, Flags 0000, IRWrite=1 and PCWrite=1 in the first cycle, DECODE next.
- ADDS R1 (Op 00, Funct 101001, Cond 1110), ALUFlags 0100 → sequence FETCH, DECODE, EXECUTEI, ALUWB; ALUControl 10; RegWrite=1 in ALUWB; Flags=0100.
- CMP (Funct 010101), ALUFlags 0110, then BEQ (Op 10, Cond 0000) → CMP has RegWrite=0 and Flags=0110; branch PCWrite=1 in BRANCH; BNE instead → PCWrite=0.
- STR with Cond 0001 while Z=1 → MEMWRITE reached with MemWrite=0.
- LDR with Rd=15 and Cond AL → MEMWB asserts RegWrite=1 and PCWrite=1.
- EOR with ALU_CTRL_W=2, and Op 11 → Undef pulses for 1 cycle in DECODE, next state FETCH, no writes.
- Reset asserted during MEMWRITE → MemWrite drops to 0 immediately and the FSM restarts at FETCH.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multicycle ARM-subset control unit: main FSM, ALU decoder with EOR/TST/CMN,
// condition check and NZCV flag register. Datapath controls are registered
// alongside the state; Undef, ImmSrc and RegSrc follow the instruction
// register combinationally because they depend on the instruction just loaded.
module multicycle_control_unit #(
    parameter int         ALU_CTRL_W = 3,
    parameter logic [3:0] PC_REG     = 4'd15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            Op,
    input  logic [5:0]            Funct,
    input  logic [3:0]            Rd,
    input  logic [3:0]            Cond,
    input  logic [3:0]            ALUFlags,
    output logic                  PCWrite,
    output logic                  MemWrite,
    output logic                  RegWrite,
    output logic                  IRWrite,
    output logic                  AdrSrc,
    output logic [1:0]            RegSrc,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [1:0]            ResultSrc,
    output logic [1:0]            ImmSrc,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic [3:0]            Flags,
    output logic                  Undef
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    // EOR needs the 3-bit control code; a narrower ALU cannot execute it.
    localparam logic EOR_OK = (ALU_CTRL_W >= 3) ? 1'b1 : 1'b0;

    // ARM condition field evaluation against the stored NZCV flags.
    function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, r;
        {n, z, c, v} = nzcv;
        case (cond)
            4'b0000: r = z;
            4'b0001: r = ~z;
            4'b0010: r = c;
            4'b0011: r = ~c;
            4'b0100: r = n;
            4'b0101: r = ~n;
            4'b0110: r = v;
            4'b0111: r = ~v;
            4'b1000: r = c & ~z;
            4'b1001: r = ~c | z;
            4'b1010: r = (n == v);
            4'b1011: r = (n != v);
            4'b1100: r = ~z & (n == v);
            4'b1101: r = z | (n != v);
            4'b1110: r = 1'b1;
            4'b1111: r = 1'b0;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    state_t          state_r;
    state_t          next_state_s;
    logic            condex_r;
    logic [3:0]      flags_r;

    logic            pcwrite_r, memwrite_r, regwrite_r, irwrite_r, adrsrc_r;
    logic [1:0]      alusrca_r, alusrcb_r, resultsrc_r;
    logic [ALU_CTRL_W-1:0] aluctrl_r;

    logic [3:0]      cmd_s;
    logic [2:0]      dec_ctrl_s;
    logic            nowrite_s;
    logic [1:0]      flagw_s;
    logic            cmd_undef_s;
    logic            undef_s;
    logic            cond_ok_s;
    logic            condex_next_s;
    logic            rd_pc_s;

    logic            n_pcwrite_s, n_memwrite_s, n_regwrite_s, n_irwrite_s, n_adrsrc_s;
    logic [1:0]      n_alusrca_s, n_alusrcb_s, n_resultsrc_s;
    logic [2:0]      n_aluctrl_s;

    assign cmd_s     = Funct[4:1];
    assign cond_ok_s = cond_check(Cond, flags_r);
    assign rd_pc_s   = (Rd == PC_REG);
    assign undef_s   = (Op == 2'b11) | ((Op == 2'b00) & cmd_undef_s);

    // The condition result becomes the predicate at the end of DECODE; states
    // entered from DECODE must already see that value.
    assign condex_next_s = (state_r == S_DECODE) ? cond_ok_s : condex_r;

    // ALU command decode: control code, result write suppression, flag write mask.
    always_comb begin
        dec_ctrl_s  = 3'b010;
        nowrite_s   = 1'b0;
        flagw_s     = 2'b00;
        cmd_undef_s = 1'b0;
        case (cmd_s)
            4'b0100: begin dec_ctrl_s = 3'b010; flagw_s = Funct[0] ? 2'b11 : 2'b00; end
            4'b0010: begin dec_ctrl_s = 3'b011; flagw_s = Funct[0] ? 2'b11 : 2'b00; end
            4'b0000: begin dec_ctrl_s = 3'b000; flagw_s = Funct[0] ? 2'b10 : 2'b00; end
            4'b1100: begin dec_ctrl_s = 3'b001; flagw_s = Funct[0] ? 2'b10 : 2'b00; end
            4'b0001: begin
                dec_ctrl_s  = 3'b100;
                flagw_s     = Funct[0] ? 2'b10 : 2'b00;
                cmd_undef_s = ~EOR_OK;
            end
            4'b1010: begin dec_ctrl_s = 3'b011; nowrite_s = 1'b1; flagw_s = 2'b11; end
            4'b1011: begin dec_ctrl_s = 3'b010; nowrite_s = 1'b1; flagw_s = 2'b11; end
            4'b1000: begin dec_ctrl_s = 3'b000; nowrite_s = 1'b1; flagw_s = 2'b10; end
            default: cmd_undef_s = 1'b1;
        endcase
    end

    // Next-state selection; undefined instructions return straight to FETCH.
    always_comb begin
        next_state_s = S_FETCH;
        case (state_r)
            S_FETCH:    next_state_s = S_DECODE;
            S_DECODE: begin
                if (undef_s) begin
                    next_state_s = S_FETCH;
                end else begin
                    case (Op)
                        2'b01:   next_state_s = S_MEMADR;
                        2'b00:   next_state_s = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                        2'b10:   next_state_s = S_BRANCH;
                        default: next_state_s = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:   next_state_s = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  next_state_s = S_MEMWB;
            S_EXECUTER: next_state_s = S_ALUWB;
            S_EXECUTEI: next_state_s = S_ALUWB;
            S_MEMWB:    next_state_s = S_FETCH;
            S_MEMWRITE: next_state_s = S_FETCH;
            S_ALUWB:    next_state_s = S_FETCH;
            S_BRANCH:   next_state_s = S_FETCH;
            default:    next_state_s = S_FETCH;
        endcase
    end

    // Control values for the state about to be entered, registered at the edge.
    always_comb begin
        n_pcwrite_s   = 1'b0;
        n_memwrite_s  = 1'b0;
        n_regwrite_s  = 1'b0;
        n_irwrite_s   = 1'b0;
        n_adrsrc_s    = 1'b0;
        n_alusrca_s   = 2'b00;
        n_alusrcb_s   = 2'b00;
        n_resultsrc_s = 2'b00;
        n_aluctrl_s   = 3'b010;
        case (next_state_s)
            S_FETCH: begin
                n_irwrite_s = 1'b1; n_pcwrite_s = 1'b1; n_adrsrc_s = 1'b0;
                n_alusrca_s = 2'b01; n_alusrcb_s = 2'b10; n_resultsrc_s = 2'b10;
                n_aluctrl_s = 3'b010;
            end
            S_DECODE: begin
                n_alusrca_s = 2'b01; n_alusrcb_s = 2'b10; n_resultsrc_s = 2'b10;
                n_aluctrl_s = 3'b010;
            end
            S_MEMADR: begin
                n_alusrca_s = 2'b00; n_alusrcb_s = 2'b01; n_aluctrl_s = 3'b010;
            end
            S_MEMREAD:  n_adrsrc_s = 1'b1;
            S_MEMWB: begin
                n_resultsrc_s = 2'b01;
                n_regwrite_s  = condex_next_s;
                n_pcwrite_s   = condex_next_s & rd_pc_s;
            end
            S_MEMWRITE: begin
                n_adrsrc_s   = 1'b1;
                n_memwrite_s = condex_next_s;
            end
            S_EXECUTER: begin
                n_alusrca_s = 2'b00; n_alusrcb_s = 2'b00; n_aluctrl_s = dec_ctrl_s;
            end
            S_EXECUTEI: begin
                n_alusrca_s = 2'b00; n_alusrcb_s = 2'b01; n_aluctrl_s = dec_ctrl_s;
            end
            S_ALUWB: begin
                n_resultsrc_s = 2'b00;
                n_regwrite_s  = condex_next_s & ~nowrite_s;
                n_pcwrite_s   = condex_next_s & ~nowrite_s & rd_pc_s;
            end
            S_BRANCH: begin
                n_alusrca_s = 2'b10; n_alusrcb_s = 2'b01; n_resultsrc_s = 2'b10;
                n_aluctrl_s = 3'b010; n_pcwrite_s = condex_next_s;
            end
            default: n_aluctrl_s = 3'b010;
        endcase
    end

    // Main FSM: state, predicate and registered datapath controls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= S_FETCH;
            condex_r    <= 1'b0;
            pcwrite_r   <= 1'b1;
            irwrite_r   <= 1'b1;
            memwrite_r  <= 1'b0;
            regwrite_r  <= 1'b0;
            adrsrc_r    <= 1'b0;
            alusrca_r   <= 2'b01;
            alusrcb_r   <= 2'b10;
            resultsrc_r <= 2'b10;
            aluctrl_r   <= ALU_CTRL_W'(3'b010);
        end else begin
            state_r     <= next_state_s;
            condex_r    <= condex_next_s;
            pcwrite_r   <= n_pcwrite_s;
            irwrite_r   <= n_irwrite_s;
            memwrite_r  <= n_memwrite_s;
            regwrite_r  <= n_regwrite_s;
            adrsrc_r    <= n_adrsrc_s;
            alusrca_r   <= n_alusrca_s;
            alusrcb_r   <= n_alusrcb_s;
            resultsrc_r <= n_resultsrc_s;
            aluctrl_r   <= ALU_CTRL_W'(n_aluctrl_s);
        end
    end

    // NZCV register: updated at the end of an execute state when the predicate holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_r <= 4'b0000;
        end else if (((state_r == S_EXECUTER) || (state_r == S_EXECUTEI)) && condex_r) begin
            if (flagw_s[1]) begin
                flags_r[3:2] <= ALUFlags[3:2];
            end
            if (flagw_s[0]) begin
                flags_r[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // FETCH enables are held in their registers through reset, so mask them
    // while reset is asserted.
    assign PCWrite    = pcwrite_r & ~reset;
    assign IRWrite    = irwrite_r & ~reset;
    assign MemWrite   = memwrite_r;
    assign RegWrite   = regwrite_r;
    assign AdrSrc     = adrsrc_r;
    assign ALUSrcA    = alusrca_r;
    assign ALUSrcB    = alusrcb_r;
    assign ResultSrc  = resultsrc_r;
    assign ALUControl = aluctrl_r;
    assign Flags      = flags_r;
    assign Undef      = (state_r == S_DECODE) & undef_s;
    assign ImmSrc     = Op;
    assign RegSrc     = {(Op == 2'b01), (Op == 2'b10)};

endmodule
